// File: rtl/mux_b_sequencer.sv
// mux_b_sequencer: control sequencer for the B-operand path (MUX_B -> Bus_B).
// Accepts instruction words over a valid/ready handshake, decodes the
// B-operand source and issues MUX_B select, constant and register-B address
// to the execute stage, one operand per handshake. Two-phase instructions
// take two issues: register operand first, then the SA field as a constant.
module mux_b_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              mb_sel,
  output logic [DATA_W-1:0] const_out,
  output logic [ADDR_W-1:0] b_addr,
  output logic              phase,
  output logic              illegal,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE1 = 2'd1;
  localparam logic [1:0] S_ISSUE2 = 2'd2;

  localparam logic [2:0] CLS_REG = 3'b000;
  localparam logic [2:0] CLS_IMM = 3'b100;
  localparam logic [2:0] CLS_TWO = 3'b101;
  localparam logic [2:0] CLS_BR  = 3'b110;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]        state;
  logic [2:0]        cls;
  logic [ADDR_W-1:0] fld_dr;
  logic [ADDR_W-1:0] fld_sa;
  logic [ADDR_W-1:0] fld_sb;
  logic              accept;
  logic              fire;
  logic              dec_legal;
  logic              dec_two;
  logic              dec_mb;
  logic [DATA_W-1:0] dec_const;
  logic [ADDR_W-1:0] sa_q;
  logic              two_q;
  logic              unused_bits;

  // Instruction fields: class on top, then DR, SA, SB in the low bits.
  assign cls    = instr_in[DATA_W-1 -: 3];
  assign fld_dr = instr_in[3*ADDR_W-1 : 2*ADDR_W];
  assign fld_sa = instr_in[2*ADDR_W-1 : ADDR_W];
  assign fld_sb = instr_in[ADDR_W-1 : 0];

  // Bits between the class and DR fields carry nothing for the B path.
  assign unused_bits = ^instr_in[DATA_W-4 : 3*ADDR_W];

  assign instr_ready = (state == S_IDLE);
  assign op_valid    = (state == S_ISSUE1) || (state == S_ISSUE2);
  assign accept      = instr_valid && instr_ready;
  assign fire        = op_valid && op_ready;

  // Decode the first-issue operand source from the incoming class.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    dec_legal = 1'b1;
    dec_two   = 1'b0;
    dec_mb    = 1'b0;
    dec_const = '0;
    case (cls)
      CLS_REG: begin
        dec_mb    = 1'b0;
        dec_const = '0;
      end
      CLS_IMM: begin
        dec_mb    = 1'b1;
        dec_const = {{(DATA_W-ADDR_W){1'b0}}, fld_sb};
      end
      CLS_BR: begin
        dec_mb    = 1'b1;
        dec_const = {{(DATA_W-2*ADDR_W){fld_dr[ADDR_W-1]}}, fld_dr, fld_sb};
      end
      CLS_TWO: begin
        dec_mb    = 1'b0;
        dec_two   = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Sequencer FSM and registered issue outputs; outputs hold between issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mb_sel    <= 1'b0;
      const_out <= '0;
      b_addr    <= '0;
      phase     <= 1'b0;
      illegal   <= 1'b0;
      sa_q      <= '0;
      two_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (dec_legal) begin
              state     <= S_ISSUE1;
              mb_sel    <= dec_mb;
              const_out <= dec_const;
              b_addr    <= fld_sb;
              phase     <= 1'b0;
              sa_q      <= fld_sa;
              two_q     <= dec_two;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        S_ISSUE1: begin
          if (op_ready) begin
            if (two_q) begin
              state     <= S_ISSUE2;
              mb_sel    <= 1'b1;
              const_out <= {{(DATA_W-ADDR_W){1'b0}}, sa_q};
              phase     <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_ISSUE2: begin
          if (op_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Saturating counters for completed issues and rejected instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt   <= '0;
      illegal_cnt <= '0;
    end else begin
      if (fire && (issue_cnt != CNT_MAX))
        issue_cnt <= issue_cnt + CNT_ONE;
      if (accept && !dec_legal && (illegal_cnt != CNT_MAX))
        illegal_cnt <= illegal_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mux_b_sequencer.sv
// Self-checking bench for mux_b_sequencer: a scoreboard queue of expected
// operands is filled by the stimulus and drained by a monitor on each op
// handshake; directed checks cover reset, illegal handling and counters.
module tb_mux_b_sequencer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic        mb_sel;
    logic [15:0] const_out;
    logic [2:0]  b_addr;
    logic        phase;
    logic        chk_const;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  // Main instance (CNT_W = 8)
  logic [15:0] instr_in;
  logic        instr_valid, instr_ready, op_valid, op_ready;
  logic        mb_sel, phase, illegal;
  logic [15:0] const_out;
  logic [2:0]  b_addr;
  logic [7:0]  issue_cnt, illegal_cnt;

  // Small-counter instance (CNT_W = 2)
  logic [15:0] instr_in_s;
  logic        instr_valid_s, instr_ready_s, op_valid_s, op_ready_s;
  logic        mb_sel_s, phase_s, illegal_s;
  logic [15:0] const_out_s;
  logic [2:0]  b_addr_s;
  logic [1:0]  issue_cnt_s, illegal_cnt_s;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic stalled = 1'b0;
  logic [20:0] held;

  always #5 clk = ~clk;

  mux_b_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .op_valid(op_valid), .op_ready(op_ready),
    .mb_sel(mb_sel), .const_out(const_out), .b_addr(b_addr), .phase(phase),
    .illegal(illegal), .issue_cnt(issue_cnt), .illegal_cnt(illegal_cnt)
  );

  mux_b_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .instr_in(instr_in_s), .instr_valid(instr_valid_s),
    .instr_ready(instr_ready_s), .op_valid(op_valid_s), .op_ready(op_ready_s),
    .mb_sel(mb_sel_s), .const_out(const_out_s), .b_addr(b_addr_s), .phase(phase_s),
    .illegal(illegal_s), .issue_cnt(issue_cnt_s), .illegal_cnt(illegal_cnt_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic m, input logic [15:0] c, input logic [2:0] a,
                              input logic p, input logic cc);
    exp_t e;
    e.mb_sel = m; e.const_out = c; e.b_addr = a; e.phase = p; e.chk_const = cc;
    return e;
  endfunction

  // Monitor: compare each handshake against the scoreboard; check stall stability.
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else if (op_valid) begin
      if (stalled) check("hold_stable", {mb_sel, const_out, b_addr, phase}, held);
      if (op_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_mb_sel", mb_sel, mon_e.mb_sel);
          check("sb_b_addr", b_addr, mon_e.b_addr);
          check("sb_phase", phase, mon_e.phase);
          if (mon_e.chk_const) check("sb_const_out", const_out, mon_e.const_out);
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = {mb_sel, const_out, b_addr, phase};
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic send(input logic [15:0] instr);
    int n = 0;
    while (!instr_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) check("ready_timeout", 0, 1);
    instr_in = instr; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic send_s(input logic [15:0] instr);
    int n = 0;
    while (!instr_ready_s && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) check("ready_s_timeout", 0, 1);
    instr_in_s = instr; instr_valid_s = 1'b1;
    @(posedge clk); #1;
    instr_valid_s = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (op_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) check("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    instr_in = '0; instr_valid = 1'b0; op_ready = 1'b0;
    instr_in_s = '0; instr_valid_s = 1'b0; op_ready_s = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // Reset state
    check("rst_instr_ready", instr_ready, 1);
    check("rst_op_valid", op_valid, 0);
    check("rst_issue_outs", {mb_sel, const_out, b_addr, phase, illegal}, 0);
    check("rst_counters", {issue_cnt, illegal_cnt}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Immediate: zero-extended SB, one-cycle latency
    op_ready = 1'b1;
    exp_q.push_back(mk(1'b1, 16'h0005, 3'd5, 1'b0, 1'b1));
    send(16'h8005);
    check("imm_latency_op_valid", op_valid, 1);
    check("imm_instr_ready_low", instr_ready, 0);
    wait_idle();
    check("imm_issue_cnt", issue_cnt, 1);
    check("imm_idle_hold_mb_sel", mb_sel, 1);

    // Branch: sign-extended {DR,SB} = 6'b111110
    exp_q.push_back(mk(1'b1, 16'hFFFE, 3'd6, 1'b0, 1'b1));
    send(16'hC1C6);
    check("br_latency_op_valid", op_valid, 1);
    wait_idle();
    check("br_issue_cnt", issue_cnt, 2);

    // Two-phase with 3-cycle stall in ISSUE1
    op_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 16'h0000, 3'd3, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 16'h0003, 3'd3, 1'b1, 1'b1));
    send(16'hA01B);
    for (int i = 0; i < 3; i++) begin
      check("two_stall_valid", op_valid, 1);
      check("two_stall_phase", phase, 0);
      @(posedge clk); #1;
    end
    check("two_stall_no_count", issue_cnt, 2);
    op_ready = 1'b1;
    @(posedge clk); #1;
    check("two_issue2_phase", phase, 1);
    check("two_issue2_valid", op_valid, 1);
    wait_idle();
    check("two_issue_cnt", issue_cnt, 4);

    // Reg-reg
    exp_q.push_back(mk(1'b0, 16'h0000, 3'd5, 1'b0, 1'b1));
    send(16'h0005);
    wait_idle();
    check("reg_issue_cnt", issue_cnt, 5);

    // Illegal classes 001 and 111
    send(16'h2000);
    check("ill_pulse", illegal, 1);
    check("ill_no_op_valid", op_valid, 0);
    check("ill_instr_ready", instr_ready, 1);
    check("ill_cnt1", illegal_cnt, 1);
    @(posedge clk); #1;
    check("ill_pulse_end", illegal, 0);
    check("ill_no_op_valid2", op_valid, 0);
    send(16'hE000);
    check("ill2_pulse", illegal, 1);
    check("ill_cnt2", illegal_cnt, 2);
    check("ill_issue_cnt_unchanged", issue_cnt, 5);
    @(posedge clk); #1;

    // Reset mid-ISSUE1: abandon operation, everything cleared immediately
    op_ready = 1'b0;
    send(16'hA01B);
    check("pre_rst_op_valid", op_valid, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_instr_ready", instr_ready, 1);
    check("mid_rst_op_valid", op_valid, 0);
    check("mid_rst_issue_outs", {mb_sel, const_out, b_addr, phase, illegal}, 0);
    check("mid_rst_counters", {issue_cnt, illegal_cnt}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    op_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_issue_cnt", issue_cnt, 0);

    // Small counters: reg-reg issues saturate at 3
    op_ready_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_s(16'h0003);
      check("sat_op_valid", op_valid_s, 1);
      check("sat_mb_sel", mb_sel_s, 0);
      check("sat_b_addr", b_addr_s, 3);
      check("sat_phase", phase_s, 0);
      @(posedge clk); #1;
      check("sat_issue_cnt", issue_cnt_s, (i + 1 > 3) ? 3 : i + 1);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
